// File: rtl/ic_tag_ctl_pkg.sv
// Shared definitions for the instruction-cache tag controller: FSM states,
// array-operation encoding, the arbitration priority and geometry defaults.
package ic_tag_ctl_pkg;

  // Default number of tag sets; must be a power of two.
  localparam int ICACHE_SETS_DEF = 128;

  // Address [31:3] as carried on the fetch/fill/array ports.
  localparam int ADDR_W     = 29;
  // Debug index width and debug tag width.
  localparam int DBG_ADDR_W = 10;
  localparam int TAG_W      = 26;
  // Ways per set.
  localparam int WAYS       = 2;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SWEEP    = 2'd1,
    ST_DBG_WAIT = 2'd2
  } ctl_state_t;

  // The single array operation chosen for a cycle.
  typedef enum logic [2:0] {
    OP_NONE     = 3'd0,
    OP_PERR_INV = 3'd1,
    OP_SWEEP    = 3'd2,
    OP_FILL     = 3'd3,
    OP_DBG      = 3'd4,
    OP_FETCH    = 3'd5
  } arr_op_t;

  // Fixed-priority arbitration of the tag array port:
  // parity invalidate > sweep > fill > debug > fetch.
  function automatic arr_op_t pick_op(input logic perr_inv,
                                      input logic sweep,
                                      input logic fill,
                                      input logic dbg,
                                      input logic fetch);
    arr_op_t op;
    op = OP_NONE;
    if (perr_inv)   op = OP_PERR_INV;
    else if (sweep) op = OP_SWEEP;
    else if (fill)  op = OP_FILL;
    else if (dbg)   op = OP_DBG;
    else if (fetch) op = OP_FETCH;
    return op;
  endfunction

endpackage

// File: rtl/ic_tag_ctl_sweep.sv
// Set counter for the fence.i invalidate sweep. The counter restarts at set 0
// whenever a flush arrives and advances one set per granted sweep cycle; a
// stalled sweep cycle (array taken by a parity invalidate) holds the count.
module ic_tag_ctl_sweep
  import ic_tag_ctl_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS_DEF,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  output logic [IDX_W-1:0] idx,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  logic [IDX_W-1:0] idx_q;

  // Set counter: restart on flush, advance on each sweep write, wrap after the last set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else if (start) begin
      idx_q <= '0;
    end else if (step) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // The sweep finishes on the cycle the last set is actually written.
  always_comb begin
    idx  = idx_q;
    done = step && (idx_q == LAST_IDX);
  end

endmodule

// File: rtl/ic_tag_ctl.sv
// Instruction-cache tag controller. Arbitrates the single tag-array port
// between parity invalidates, the fence.i sweep, miss fills, debug tag reads
// and fetch lookups, and tracks the one-cycle array latency of lookups and
// debug reads.
//
// Request/grant semantics: fill and fetch requests are level requests that the
// requester holds until the matching *_gnt is seen high in the same cycle; the
// operation is issued to the array in that cycle and the request may drop at
// the next edge. Debug requests are held until io_dbg_done. A flush request is
// a one-cycle pulse and is never refused. Lookup results come back exactly one
// cycle after io_ic_rd_en and are always delivered, even across a flush.
module ic_tag_ctl
  import ic_tag_ctl_pkg::*;
#(
  parameter int ICACHE_SETS = ICACHE_SETS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  // flush / fence.i
  input  logic                  io_flush_req,
  output logic                  io_flush_busy,
  // fetch lookup
  input  logic                  io_fetch_req,
  input  logic [ADDR_W-1:0]     io_fetch_addr,
  output logic                  io_fetch_gnt,
  output logic                  io_fetch_rsp_valid,
  output logic [WAYS-1:0]       io_fetch_hit,
  output logic                  io_fetch_perr,
  // miss fill
  input  logic                  io_fill_req,
  input  logic [ADDR_W-1:0]     io_fill_addr,
  input  logic [WAYS-1:0]       io_fill_way,
  output logic                  io_fill_gnt,
  // debug tag read
  input  logic                  io_dbg_req,
  input  logic [DBG_ADDR_W-1:0] io_dbg_addr,
  input  logic [WAYS-1:0]       io_dbg_way,
  output logic                  io_dbg_done,
  output logic [TAG_W-1:0]      io_dbg_rdata,
  // tag array
  output logic [ADDR_W-1:0]     io_ic_rw_addr,
  output logic [WAYS-1:0]       io_ic_wr_en,
  output logic [WAYS-1:0]       io_ic_tag_valid,
  output logic                  io_ic_rd_en,
  output logic [DBG_ADDR_W-1:0] io_ic_debug_addr,
  output logic [WAYS-1:0]       io_ic_debug_way,
  output logic                  io_ic_debug_rd_en,
  input  logic [TAG_W-1:0]      io_ictag_debug_rd_data,
  input  logic [WAYS-1:0]       io_ic_rd_hit,
  input  logic                  io_ic_tag_perr,
  // controller state, for observation only
  output ctl_state_t            io_ctl_state
);

  localparam int IDX_W = $clog2(ICACHE_SETS);

  ctl_state_t       state_q;
  ctl_state_t       state_d;
  arr_op_t          op;

  logic             perr_inv;
  logic             fill_ok;
  logic             dbg_ok;
  logic             rsp_pend_q;
  logic [IDX_W-1:0] fetch_idx_q;
  logic             dbg_done_q;
  logic [TAG_W-1:0] dbg_rdata_q;
  logic [IDX_W-1:0] sweep_idx;
  logic             sweep_done;
  logic [ADDR_W-1:0] idx_addr;

  ic_tag_ctl_sweep #(
    .SETS  (ICACHE_SETS),
    .IDX_W (IDX_W)
  ) u_sweep (
    .clock (clock),
    .reset (reset),
    .start (io_flush_req),
    .step  (op == OP_SWEEP),
    .idx   (sweep_idx),
    .done  (sweep_done)
  );

  // Arbitration: pick the one array operation for this cycle. Requests are
  // gated by reset so nothing reaches the array while reset is low.
  always_comb begin
    perr_inv = rsp_pend_q && io_ic_tag_perr;
    // Fills would be wiped by the sweep anyway, so they wait it out.
    fill_ok  = io_fill_req && (state_q != ST_SWEEP);
    // Debug only from IDLE, not while the previous done is still showing
    // (requester drops its level request one cycle later), and not in a
    // flush cycle, which would lose the read in flight.
    dbg_ok   = io_dbg_req && (state_q == ST_IDLE) && !dbg_done_q && !io_flush_req;
    if (reset) begin
      op = pick_op(perr_inv, state_q == ST_SWEEP, fill_ok, dbg_ok, io_fetch_req);
    end else begin
      op = OP_NONE;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a flush from any state (re)starts the sweep.
  always_comb begin
    state_d = state_q;
    if (io_flush_req) begin
      state_d = ST_SWEEP;
    end else begin
      case (state_q)
        ST_IDLE:     if (op == OP_DBG) state_d = ST_DBG_WAIT;
        ST_SWEEP:    if (sweep_done)   state_d = ST_IDLE;
        ST_DBG_WAIT: state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Array-side drive for the chosen operation; everything is zero otherwise.
  always_comb begin
    io_ic_rw_addr     = '0;
    io_ic_wr_en       = '0;
    io_ic_tag_valid   = '0;
    io_ic_rd_en       = 1'b0;
    io_ic_debug_addr  = '0;
    io_ic_debug_way   = '0;
    io_ic_debug_rd_en = 1'b0;
    io_fill_gnt       = 1'b0;
    io_fetch_gnt      = 1'b0;
    idx_addr          = '0;
    case (op)
      OP_PERR_INV: begin
        // Drop both ways of the set whose lookup just reported bad parity.
        idx_addr[IDX_W-1:0] = fetch_idx_q;
        io_ic_rw_addr       = idx_addr;
        io_ic_wr_en         = '1;
      end
      OP_SWEEP: begin
        idx_addr[IDX_W-1:0] = sweep_idx;
        io_ic_rw_addr       = idx_addr;
        io_ic_wr_en         = '1;
      end
      OP_FILL: begin
        io_ic_rw_addr   = io_fill_addr;
        io_ic_wr_en     = io_fill_way;
        io_ic_tag_valid = io_fill_way;
        io_fill_gnt     = 1'b1;
      end
      OP_DBG: begin
        io_ic_debug_addr  = io_dbg_addr;
        io_ic_debug_way   = io_dbg_way;
        io_ic_debug_rd_en = 1'b1;
      end
      OP_FETCH: begin
        io_ic_rw_addr = io_fetch_addr;
        io_ic_rd_en   = 1'b1;
        io_fetch_gnt  = 1'b1;
      end
      default: ;
    endcase
  end

  // Track in-flight lookups and debug reads across the one-cycle array latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_pend_q  <= 1'b0;
      fetch_idx_q <= '0;
      dbg_done_q  <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      rsp_pend_q <= (op == OP_FETCH);
      if (op == OP_FETCH) begin
        fetch_idx_q <= io_fetch_addr[IDX_W-1:0];
      end
      // Array debug data is valid during DBG_WAIT; done shows with it registered.
      dbg_done_q <= (state_q == ST_DBG_WAIT);
      if (state_q == ST_DBG_WAIT) begin
        dbg_rdata_q <= io_ictag_debug_rd_data;
      end
    end
  end

  // Requester-side outputs; a parity error forces the hit vector to zero.
  always_comb begin
    io_flush_busy      = (state_q == ST_SWEEP);
    io_fetch_rsp_valid = rsp_pend_q;
    io_fetch_perr      = rsp_pend_q && io_ic_tag_perr;
    io_fetch_hit       = (rsp_pend_q && !io_ic_tag_perr) ? io_ic_rd_hit : '0;
    io_dbg_done        = dbg_done_q;
    io_dbg_rdata       = dbg_rdata_q;
    io_ctl_state       = state_q;
  end

endmodule

// File: tb/tb_ic_tag_ctl.sv
// Directed bench for ic_tag_ctl: arbitration, lookup responses, parity
// invalidate, debug reads, fence.i sweeps (including restart) and reset.
module tb_ic_tag_ctl;
  import ic_tag_ctl_pkg::*;

  localparam int SETS = 128;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic                  io_flush_req;
  logic                  io_flush_busy;
  logic                  io_fetch_req;
  logic [ADDR_W-1:0]     io_fetch_addr;
  logic                  io_fetch_gnt;
  logic                  io_fetch_rsp_valid;
  logic [WAYS-1:0]       io_fetch_hit;
  logic                  io_fetch_perr;
  logic                  io_fill_req;
  logic [ADDR_W-1:0]     io_fill_addr;
  logic [WAYS-1:0]       io_fill_way;
  logic                  io_fill_gnt;
  logic                  io_dbg_req;
  logic [DBG_ADDR_W-1:0] io_dbg_addr;
  logic [WAYS-1:0]       io_dbg_way;
  logic                  io_dbg_done;
  logic [TAG_W-1:0]      io_dbg_rdata;
  logic [ADDR_W-1:0]     io_ic_rw_addr;
  logic [WAYS-1:0]       io_ic_wr_en;
  logic [WAYS-1:0]       io_ic_tag_valid;
  logic                  io_ic_rd_en;
  logic [DBG_ADDR_W-1:0] io_ic_debug_addr;
  logic [WAYS-1:0]       io_ic_debug_way;
  logic                  io_ic_debug_rd_en;
  logic [TAG_W-1:0]      io_ictag_debug_rd_data;
  logic [WAYS-1:0]       io_ic_rd_hit;
  logic                  io_ic_tag_perr;
  ctl_state_t            io_ctl_state;

  ic_tag_ctl #(.ICACHE_SETS(SETS)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_flush_req           (io_flush_req),
    .io_flush_busy          (io_flush_busy),
    .io_fetch_req           (io_fetch_req),
    .io_fetch_addr          (io_fetch_addr),
    .io_fetch_gnt           (io_fetch_gnt),
    .io_fetch_rsp_valid     (io_fetch_rsp_valid),
    .io_fetch_hit           (io_fetch_hit),
    .io_fetch_perr          (io_fetch_perr),
    .io_fill_req            (io_fill_req),
    .io_fill_addr           (io_fill_addr),
    .io_fill_way            (io_fill_way),
    .io_fill_gnt            (io_fill_gnt),
    .io_dbg_req             (io_dbg_req),
    .io_dbg_addr            (io_dbg_addr),
    .io_dbg_way             (io_dbg_way),
    .io_dbg_done            (io_dbg_done),
    .io_dbg_rdata           (io_dbg_rdata),
    .io_ic_rw_addr          (io_ic_rw_addr),
    .io_ic_wr_en            (io_ic_wr_en),
    .io_ic_tag_valid        (io_ic_tag_valid),
    .io_ic_rd_en            (io_ic_rd_en),
    .io_ic_debug_addr       (io_ic_debug_addr),
    .io_ic_debug_way        (io_ic_debug_way),
    .io_ic_debug_rd_en      (io_ic_debug_rd_en),
    .io_ictag_debug_rd_data (io_ictag_debug_rd_data),
    .io_ic_rd_hit           (io_ic_rd_hit),
    .io_ic_tag_perr         (io_ic_tag_perr),
    .io_ctl_state           (io_ctl_state)
  );

  // OR of every DUT output, for the all-zero-in-reset checks.
  logic all_nz;
  assign all_nz = |{io_flush_busy, io_fetch_gnt, io_fetch_rsp_valid, io_fetch_hit,
                    io_fetch_perr, io_fill_gnt, io_dbg_done, io_dbg_rdata,
                    io_ic_rw_addr, io_ic_wr_en, io_ic_tag_valid, io_ic_rd_en,
                    io_ic_debug_addr, io_ic_debug_way, io_ic_debug_rd_en,
                    io_ctl_state};

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    logic [31:0] want;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=0x%0h expected=<nothing queued>", tag, obs);
    end else begin
      want = exp_q.pop_front();
      chk(tag, obs, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic push_sweep();
    for (int k = 0; k < SETS; k++) exp_q.push_back(32'(k));
  endtask

  // Follow a sweep from its current cycle until busy drops (bounded); return busy-cycle count.
  task automatic sweep_run(output int n);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      mid();
      if (!io_flush_busy) break;
      n++;
      chk_pop("sweep_idx", 32'(io_ic_rw_addr));
      chk("sweep_wr_en", 32'(io_ic_wr_en), 32'h3);
      chk("sweep_valid", 32'(io_ic_tag_valid), 32'h0);
      chk("sweep_no_fill", 32'(io_fill_gnt), 32'h0);
      tick();
    end
  endtask

  logic [1:0]        hv;
  logic [1:0]        b2b_hit[3];
  logic [ADDR_W-1:0] b2b_addr;
  int                n_busy;

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    io_flush_req = 0; io_fetch_req = 0; io_fetch_addr = '0;
    io_fill_addr = '0; io_dbg_addr = '0; io_dbg_way = '0;
    io_ictag_debug_rd_data = '0; io_ic_rd_hit = '0; io_ic_tag_perr = 0;
    // Requests held during reset must not reach the array.
    io_fill_req = 1; io_fill_way = 2'b01; io_fetch_req = 1; io_dbg_req = 1;
    repeat (3) @(posedge clock);
    mid();
    chk("reset_outs_zero", 32'(all_nz), 32'h0);
    chk("reset_state", 32'(io_ctl_state), 32'(ST_IDLE));
    io_fill_req = 0; io_fetch_req = 0; io_dbg_req = 0;
    reset = 1;
    tick();

    // Fill beats fetch in the same cycle; fetch goes next cycle.
    io_fill_req = 1; io_fill_addr = 29'h123; io_fill_way = 2'b10;
    io_fetch_req = 1; io_fetch_addr = 29'h55;
    mid();
    chk("arb_fill_gnt", 32'(io_fill_gnt), 32'h1);
    chk("arb_fetch_blocked", 32'(io_fetch_gnt), 32'h0);
    chk("fill_wr_en", 32'(io_ic_wr_en), 32'h2);
    chk("fill_valid", 32'(io_ic_tag_valid), 32'h2);
    chk("fill_addr", 32'(io_ic_rw_addr), 32'h123);
    chk("fill_no_rd", 32'(io_ic_rd_en), 32'h0);
    tick();
    io_fill_req = 0;
    mid();
    chk("arb_fetch_next", 32'(io_fetch_gnt), 32'h1);
    chk("fetch_rd_en", 32'(io_ic_rd_en), 32'h1);
    chk("fetch_addr", 32'(io_ic_rw_addr), 32'h55);
    chk("fetch_no_wr", 32'(io_ic_wr_en), 32'h0);
    hv = 2'($urandom_range(0, 3));
    exp_q.push_back({29'b0, hv, 1'b0});
    tick();
    io_fetch_req = 0; io_ic_rd_hit = hv;
    mid();
    chk("rsp_valid", 32'(io_fetch_rsp_valid), 32'h1);
    chk_pop("fetch_rsp", {29'b0, io_fetch_hit, io_fetch_perr});
    chk("rsp_no_array_op", 32'({io_ic_wr_en, io_ic_rd_en}), 32'h0);
    tick();
    io_ic_rd_hit = '0;
    mid();
    chk("rsp_valid_drop", 32'(io_fetch_rsp_valid), 32'h0);

    // Back-to-back fetch grants, responses in order.
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i > 0) io_ic_rd_hit = b2b_hit[i-1];
      io_fetch_req = (i < 3);
      if (i < 3) begin
        b2b_addr = 29'($urandom);
        b2b_hit[i] = 2'($urandom_range(0, 3));
        io_fetch_addr = b2b_addr;
        exp_q.push_back({29'b0, b2b_hit[i], 1'b0});
      end
      mid();
      if (i < 3) begin
        chk("b2b_gnt", 32'(io_fetch_gnt), 32'h1);
        chk("b2b_addr", 32'(io_ic_rw_addr), 32'(b2b_addr));
      end
      if (i > 0) begin
        chk("b2b_rsp_valid", 32'(io_fetch_rsp_valid), 32'h1);
        chk_pop("b2b_rsp", {29'b0, io_fetch_hit, io_fetch_perr});
      end
    end
    tick();
    io_ic_rd_hit = '0;

    // Parity error on lookup of address 0x40 (index 8).
    io_fetch_req = 1; io_fetch_addr = 29'(32'h40 >> 3);
    mid();
    chk("perr_fetch_gnt", 32'(io_fetch_gnt), 32'h1);
    exp_q.push_back({29'b0, 2'b00, 1'b1});
    tick();
    io_fetch_req = 0; io_ic_tag_perr = 1; io_ic_rd_hit = 2'b11;
    io_fill_req = 1; io_fill_addr = 29'h777; io_fill_way = 2'b01;
    mid();
    chk("perr_rsp_valid", 32'(io_fetch_rsp_valid), 32'h1);
    chk_pop("perr_rsp", {29'b0, io_fetch_hit, io_fetch_perr});
    chk("perr_wr_en", 32'(io_ic_wr_en), 32'h3);
    chk("perr_valid", 32'(io_ic_tag_valid), 32'h0);
    chk("perr_index", 32'(io_ic_rw_addr), 32'h8);
    chk("perr_blocks_fill", 32'(io_fill_gnt), 32'h0);
    tick();
    io_ic_tag_perr = 0; io_ic_rd_hit = '0;
    mid();
    chk("fill_after_perr", 32'(io_fill_gnt), 32'h1);
    chk("fill_after_perr_addr", 32'(io_ic_rw_addr), 32'h777);
    tick();
    io_fill_req = 0;

    // Debug read of index 5, way 0.
    io_dbg_req = 1; io_dbg_addr = 10'd5; io_dbg_way = 2'b01;
    mid();
    chk("dbg_rd_en", 32'(io_ic_debug_rd_en), 32'h1);
    chk("dbg_addr", 32'(io_ic_debug_addr), 32'h5);
    chk("dbg_way", 32'(io_ic_debug_way), 32'h1);
    exp_q.push_back(32'h2ABCDEF);
    tick();
    io_ictag_debug_rd_data = 26'h2ABCDEF;
    mid();
    chk("dbg_wait_state", 32'(io_ctl_state), 32'(ST_DBG_WAIT));
    chk("dbg_done_early", 32'(io_dbg_done), 32'h0);
    chk("dbg_single_rd", 32'(io_ic_debug_rd_en), 32'h0);
    tick();
    io_ictag_debug_rd_data = '0;
    mid();
    chk("dbg_done", 32'(io_dbg_done), 32'h1);
    chk_pop("dbg_rdata", 32'(io_dbg_rdata));
    chk("dbg_no_regrant", 32'(io_ic_debug_rd_en), 32'h0);
    tick();
    io_dbg_req = 0;
    mid();
    chk("dbg_done_pulse", 32'(io_dbg_done), 32'h0);
    chk("dbg_rdata_hold", 32'(io_dbg_rdata), 32'h2ABCDEF);

    // Flush with a fetch issued in the flush cycle; its response must survive.
    tick();
    io_flush_req = 1; io_fetch_req = 1; io_fetch_addr = 29'h3;
    mid();
    chk("flush_cycle_fetch_gnt", 32'(io_fetch_gnt), 32'h1);
    chk("flush_cycle_not_busy", 32'(io_flush_busy), 32'h0);
    tick();
    io_flush_req = 0; io_fetch_req = 0; io_ic_rd_hit = 2'b10;
    io_fill_req = 1; io_fill_addr = 29'h99; io_fill_way = 2'b10;
    push_sweep();
    #1;
    chk("flush_rsp_valid", 32'(io_fetch_rsp_valid), 32'h1);
    chk("flush_rsp_hit", 32'(io_fetch_hit), 32'h2);
    sweep_run(n_busy);
    io_ic_rd_hit = '0;
    chk("sweep_busy_cycles", 32'(n_busy), 32'(SETS));
    chk("sweep_all_sets", 32'(exp_q.size()), 32'h0);
    chk("fill_after_sweep", 32'(io_fill_gnt), 32'h1);
    chk("fill_after_sweep_addr", 32'(io_ic_rw_addr), 32'h99);
    tick();
    io_fill_req = 0;

    // Flush again during the sweep at set 60: restart from set 0.
    io_flush_req = 1;
    push_sweep();
    tick();
    io_flush_req = 0;
    for (int c = 0; c <= 60; c++) begin
      io_flush_req = (c == 60);
      mid();
      chk_pop("pre_restart_idx", 32'(io_ic_rw_addr));
      chk("pre_restart_busy", 32'(io_flush_busy), 32'h1);
      tick();
    end
    io_flush_req = 0;
    exp_q.delete();
    push_sweep();
    sweep_run(n_busy);
    chk("restart_busy_cycles", 32'(n_busy), 32'(SETS));
    chk("restart_all_sets", 32'(exp_q.size()), 32'h0);
    tick();

    // Reset asserted while a debug read is waiting for data.
    io_dbg_req = 1; io_dbg_addr = 10'd9; io_dbg_way = 2'b10;
    mid();
    chk("rst_dbg_gnt", 32'(io_ic_debug_rd_en), 32'h1);
    tick();
    io_ictag_debug_rd_data = 26'h155; io_fill_req = 1;
    mid();
    chk("rst_dbg_wait", 32'(io_ctl_state), 32'(ST_DBG_WAIT));
    #2 reset = 0;
    #1;
    chk("rst_outs_zero", 32'(all_nz), 32'h0);
    chk("rst_state_idle", 32'(io_ctl_state), 32'(ST_IDLE));
    tick();
    mid();
    io_dbg_req = 0; io_fill_req = 0; io_ictag_debug_rd_data = '0;
    reset = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      mid();
      chk("rst_no_dbg_done", 32'(io_dbg_done), 32'h0);
      chk("rst_rdata_cleared", 32'(io_dbg_rdata), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
